// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default stage widths, the NOP encoding and the
// control-field bit positions used by the decoder and every stage register.
package pipe_pkg;

  localparam int PIPE_DATA_W = 96;
  localparam int PIPE_CTRL_W = 8;
  localparam int PIPE_CNT_W  = 16;

  localparam logic [31:0] PIPE_NOP_INSN = 32'h0000_0000;

  // Control payload layout; an all-zero control word behaves as a NOP downstream.
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_JAL        = 4;
  localparam int CTRL_JALR       = 5;
  localparam int CTRL_BRANCH     = 6;
  localparam int CTRL_OP2_SRC    = 7;

  typedef struct packed {
    logic full;
    logic load;
    logic unload;
  } skid_ctl_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Single storage entry with a full flag; holds the word accepted while the
// main stage register is stalled.
module pipe_skid_buf import pipe_pkg::*; #(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              unload,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Load wins over unload so a refill in the draining cycle keeps the entry full.
  always_ff @(posedge clock) begin
    if (reset) begin
      full <= 1'b0;
      data <= {DATA_W{1'b0}};
      ctrl <= {CTRL_W{1'b0}};
    end else if (clear) begin
      full <= 1'b0;
      ctrl <= {CTRL_W{1'b0}};
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
      ctrl <= load_ctrl;
    end else if (unload) begin
      full <= 1'b0;
      ctrl <= {CTRL_W{1'b0}};
    end else begin
      full <= full;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage register with flush and saturating stall counter.
// Define PIPE_SKID_EN to add a skid entry and register the in_ready path.
module pipe_stage_hs import pipe_pkg::*; #(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  logic              pop;
  logic              accept;
  logic              main_load;
  logic [DATA_W-1:0] load_data;
  logic [CTRL_W-1:0] load_ctrl;

  assign pop    = out_valid && out_ready;
  assign accept = in_valid && in_ready && !flush;

`ifdef PIPE_SKID_EN
  logic              skid_full;
  logic              skid_load;
  logic              skid_unload;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign in_ready = flush || !skid_full;

  // Route the incoming word to main or skid; skid always refills main first.
  always_comb begin
    main_load   = 1'b0;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    load_data   = in_data;
    load_ctrl   = in_ctrl;
    if (!out_valid || pop) begin
      if (skid_full) begin
        main_load   = 1'b1;
        skid_unload = 1'b1;
        skid_load   = accept;
        load_data   = skid_data;
        load_ctrl   = skid_ctrl;
      end else begin
        main_load = accept;
      end
    end else begin
      skid_load = accept;
    end
  end

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .load      (skid_load),
    .unload    (skid_unload),
    .load_data (in_data),
    .load_ctrl (in_ctrl),
    .full      (skid_full),
    .data      (skid_data),
    .ctrl      (skid_ctrl)
  );
`else
  assign in_ready  = flush || !out_valid || out_ready;
  assign main_load = accept;
  assign load_data = in_data;
  assign load_ctrl = in_ctrl;
`endif

  // Main stage register; control is zeroed on flush and bubble, data is held.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
      out_ctrl  <= {CTRL_W{1'b0}};
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= {CTRL_W{1'b0}};
    end else if (main_load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_ctrl  <= load_ctrl;
    end else if (pop) begin
      out_valid <= 1'b0;
      out_ctrl  <= {CTRL_W{1'b0}};
    end else begin
      out_valid <= out_valid;
    end
  end

  // Stall counter saturates at all-ones; clear beats increment and flush is ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (stall_clr) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs: vector table, directed corner sequences
// and random traffic against a queue-based reference model.
module tb_pipe_stage_hs;
  import pipe_pkg::*;

  localparam int DW = 96;
  localparam int CW = 8;
  localparam int NW = 4;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          flush;
  logic [NW-1:0] stall_cnt;
  logic          stall_clr;

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int accepts = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } word_t;

  word_t         q[$];
  logic [DW-1:0] m_last = '0;
  logic [NW-1:0] m_cnt = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_in_ready();
    if (flush) return 1'b1;
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  task automatic model_update();
    bit rdy;
    if (reset) begin
      q.delete();
      m_last = '0;
      m_cnt  = '0;
      return;
    end
    rdy = model_in_ready();
    if (stall_clr) m_cnt = '0;
    else if (q.size() != 0 && !out_ready && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && rdy) q.push_back('{d: in_data, c: in_ctrl});
    end
    if (q.size() != 0) m_last = q[0].d;
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input logic ordy, input logic fl,
                       input logic clr);
    reset = rst; in_valid = iv; in_data = d; in_ctrl = c;
    out_ready = ordy; flush = fl; stall_clr = clr;
  endtask

  // One clock: check in_ready before the edge, outputs against the model after it.
  task automatic step();
    #1;
    if (!reset) begin
      check("in_ready_model", in_ready, model_in_ready());
      if (in_valid && in_ready && !flush) accepts++;
    end
    @(posedge clock);
    model_update();
    #1;
    check("out_valid_model", out_valid, q.size() != 0);
    check("out_data_model", out_data, (q.size() != 0) ? q[0].d : m_last);
    check("out_ctrl_model", out_ctrl, (q.size() != 0) ? q[0].c : 8'h00);
    check("stall_cnt_model", stall_cnt, m_cnt);
    @(negedge clock);
  endtask

  typedef struct {
    logic          rst;
    logic          iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          ordy;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic [CW-1:0] exp_c;
    logic [NW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[12];
  int   acc0;

  initial begin
    // Table: word, reset mid-stream, stream 1..8, then two bubble cycles.
    vecs[0] = '{1'b0, 1'b1, 96'hA5, 8'hFF, 1'b1, 1'b1, 96'hA5, 8'hFF, 4'd0};
    vecs[1] = '{1'b1, 1'b1, 96'hA5, 8'hFF, 1'b1, 1'b0, 96'h0, 8'h00, 4'd0};
    for (int i = 1; i <= 8; i++)
      vecs[i+1] = '{1'b0, 1'b1, DW'(i), CW'(i), 1'b1, 1'b1, DW'(i), CW'(i), 4'd0};
    vecs[10] = '{1'b0, 1'b0, 96'h0, 8'h00, 1'b1, 1'b0, 96'h8, 8'h00, 4'd0};
    vecs[11] = '{1'b0, 1'b0, 96'h0, 8'h00, 1'b1, 1'b0, 96'h8, 8'h00, 4'd0};

    drive(1'b1, 1'b0, 96'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    step();
    drive(1'b0, 1'b0, 96'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 96'h0);
    check("reset_stall_cnt", stall_cnt, 4'd0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy, 1'b0, 1'b0);
      step();
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_v);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_d);
      check($sformatf("vec%0d_ctrl", i), out_ctrl, vecs[i].exp_c);
      check($sformatf("vec%0d_cnt", i), stall_cnt, vecs[i].exp_cnt);
    end

    // Stall: hold 0x100/0x81 for five cycles while 0x101 is offered.
    drive(1'b0, 1'b1, 96'h100, 8'h81, 1'b0, 1'b0, 1'b0);
    step();
    acc0 = accepts;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 96'h101, 8'h02, 1'b0, 1'b0, 1'b0);
      step();
      check("stall_hold_valid", out_valid, 1'b1);
      check("stall_hold_data", out_data, 96'h100);
      check("stall_hold_ctrl", out_ctrl, 8'h81);
    end
    check("stall_cnt_5", stall_cnt, 4'd5);
    #1;
    check("stall_in_ready_low", in_ready, 1'b0);
    check("stall_extra_accepts", accepts - acc0, SKID ? 1 : 0);
    drive(1'b0, !SKID, 96'h101, 8'h02, 1'b1, 1'b0, 1'b0);
    step();
    check("release_data", out_data, 96'h101);
    check("release_ctrl", out_ctrl, 8'h02);
    check("release_valid", out_valid, 1'b1);
    drive(1'b0, 1'b0, 96'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    check("drained_valid", out_valid, 1'b0);

    // Flush with a full stage and a word arriving in the flush cycle.
    drive(1'b0, 1'b1, 96'h200, 8'h11, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 96'h201, 8'h22, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 96'h2FF, 8'h55, 1'b0, 1'b1, 1'b0);
    #1;
    check("flush_in_ready", in_ready, 1'b1);
    step();
    check("flush_valid", out_valid, 1'b0);
    check("flush_ctrl", out_ctrl, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 96'h0, 8'h00, 1'b1, 1'b0, 1'b0);
      step();
      check("post_flush_valid", out_valid, 1'b0);
    end

    // Counter saturation and clear-during-stall.
    drive(1'b0, 1'b0, 96'h0, 8'h00, 1'b1, 1'b0, 1'b1);
    step();
    check("cnt_cleared", stall_cnt, 4'd0);
    drive(1'b0, 1'b1, 96'h300, 8'h33, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 96'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      step();
    end
    check("cnt_saturated", stall_cnt, 4'd15);
    drive(1'b0, 1'b0, 96'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    step();
    check("cnt_clr_wins", stall_cnt, 4'd0);
    drive(1'b0, 1'b0, 96'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    check("cnt_restart", stall_cnt, 4'd1);
    drive(1'b0, 1'b0, 96'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    step();

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(99, 0) < 1, $urandom_range(99, 0) < 70,
            {$urandom, $urandom, $urandom}, CW'($urandom),
            $urandom_range(99, 0) < 60, $urandom_range(99, 0) < 4,
            $urandom_range(99, 0) < 4);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
